// File: rtl/rv_isa_pkg.sv
// RV32I encoding constants shared by the instruction encoder and the decode-side immediate generator.
package rv_isa_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam int IMM_I_MIN = -2048;
  localparam int IMM_I_MAX = 2047;
  localparam int IMM_B_MIN = -4096;
  localparam int IMM_B_MAX = 4094;
  localparam int IMM_J_MIN = -1048576;
  localparam int IMM_J_MAX = 1048574;

  function automatic logic imm_in_range(input logic [31:0] imm, input int lo, input int hi);
    return ($signed(imm) >= lo) && ($signed(imm) <= hi);
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Scatters a full immediate into its instruction bit positions for one format and flags
// values the format cannot represent; illegal immediates pack as all zeros.
module imm_pack
  import rv_isa_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [31:0] imm,
  output logic [31:0] imm_bits,
  output logic        err
);

  always_comb begin
    imm_bits = '0;
    err      = 1'b0;
    case (fmt)
      FMT_R: ;
      FMT_I: begin
        err      = !imm_in_range(imm, IMM_I_MIN, IMM_I_MAX);
        imm_bits = {imm[11:0], 20'b0};
      end
      FMT_S: begin
        err      = !imm_in_range(imm, IMM_I_MIN, IMM_I_MAX);
        imm_bits = {imm[11:5], 13'b0, imm[4:0], 7'b0};
      end
      FMT_B: begin
        err      = !imm_in_range(imm, IMM_B_MIN, IMM_B_MAX) || imm[0];
        imm_bits = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
      end
      FMT_U: begin
        err      = |imm[11:0];
        imm_bits = {imm[31:12], 12'b0};
      end
      FMT_J: begin
        err      = !imm_in_range(imm, IMM_J_MIN, IMM_J_MAX) || imm[0];
        imm_bits = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
      end
      default: err = 1'b1;
    endcase
    if (err) imm_bits = '0;
  end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage RV32I encoder: S1 holds the fields and legality flag, S2 holds the packed word.
// Valid/ready on both sides with saturating delivered-word and error counters.
module instr_encoder
  import rv_isa_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] cnt_words,
  output logic [CNT_W-1:0] cnt_errs
);

  logic             s1_valid_q, s1_valid_d;
  logic [2:0]       s1_fmt_q, s1_fmt_d;
  logic [6:0]       s1_opcode_q, s1_opcode_d;
  logic [4:0]       s1_rd_q, s1_rd_d;
  logic [4:0]       s1_rs1_q, s1_rs1_d;
  logic [4:0]       s1_rs2_q, s1_rs2_d;
  logic [2:0]       s1_funct3_q, s1_funct3_d;
  logic [6:0]       s1_funct7_q, s1_funct7_d;
  logic [31:0]      s1_imm_bits_q, s1_imm_bits_d;
  logic             s1_err_q, s1_err_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_instr_q, out_instr_d;
  logic             out_err_q, out_err_d;
  logic [CNT_W-1:0] cnt_words_q, cnt_words_d;
  logic [CNT_W-1:0] cnt_errs_q, cnt_errs_d;

  logic [31:0] pack_imm_bits;
  logic        pack_err;
  logic        s2_en;
  logic        in_fire;
  logic        out_fire;
  logic [31:0] word;

  imm_pack u_imm_pack (
    .fmt      (in_fmt),
    .imm      (in_imm),
    .imm_bits (pack_imm_bits),
    .err      (pack_err)
  );

  // in_ready is built from stage state and out_ready only, never from in_valid.
  assign s2_en    = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_en;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_fmt_d      = s1_fmt_q;
    s1_opcode_d   = s1_opcode_q;
    s1_rd_d       = s1_rd_q;
    s1_rs1_d      = s1_rs1_q;
    s1_rs2_d      = s1_rs2_q;
    s1_funct3_d   = s1_funct3_q;
    s1_funct7_d   = s1_funct7_q;
    s1_imm_bits_d = s1_imm_bits_q;
    s1_err_d      = s1_err_q;
    if (in_ready) s1_valid_d = in_valid;
    if (in_fire) begin
      s1_fmt_d      = in_fmt;
      s1_opcode_d   = in_opcode;
      s1_rd_d       = in_rd;
      s1_rs1_d      = in_rs1;
      s1_rs2_d      = in_rs2;
      s1_funct3_d   = in_funct3;
      s1_funct7_d   = in_funct7;
      s1_imm_bits_d = pack_imm_bits;
      s1_err_d      = pack_err;
    end
  end

  // Non-immediate fields per format; immediate bits are OR-ed in already masked.
  always_comb begin
    word = '0;
    case (s1_fmt_q)
      FMT_R:        word = {s1_funct7_q, s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
      FMT_I:        word = {12'b0, s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
      FMT_S, FMT_B: word = {7'b0, s1_rs2_q, s1_rs1_q, s1_funct3_q, 5'b0, s1_opcode_q};
      FMT_U, FMT_J: word = {20'b0, s1_rd_q, s1_opcode_q};
      default:      word = '0;
    endcase
    word = word | s1_imm_bits_q;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_err_d   = out_err_q;
    if (s2_en) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_instr_d = word;
        out_err_d   = s1_err_q;
      end
    end
    cnt_words_d = cnt_words_q;
    cnt_errs_d  = cnt_errs_q;
    if (out_fire && !(&cnt_words_q)) cnt_words_d = cnt_words_q + 1'b1;
    if (out_fire && out_err_q && !(&cnt_errs_q)) cnt_errs_d = cnt_errs_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_fmt_q      <= '0;
      s1_opcode_q   <= '0;
      s1_rd_q       <= '0;
      s1_rs1_q      <= '0;
      s1_rs2_q      <= '0;
      s1_funct3_q   <= '0;
      s1_funct7_q   <= '0;
      s1_imm_bits_q <= '0;
      s1_err_q      <= 1'b0;
      out_valid_q   <= 1'b0;
      out_instr_q   <= '0;
      out_err_q     <= 1'b0;
      cnt_words_q   <= '0;
      cnt_errs_q    <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_fmt_q      <= s1_fmt_d;
      s1_opcode_q   <= s1_opcode_d;
      s1_rd_q       <= s1_rd_d;
      s1_rs1_q      <= s1_rs1_d;
      s1_rs2_q      <= s1_rs2_d;
      s1_funct3_q   <= s1_funct3_d;
      s1_funct7_q   <= s1_funct7_d;
      s1_imm_bits_q <= s1_imm_bits_d;
      s1_err_q      <= s1_err_d;
      out_valid_q   <= out_valid_d;
      out_instr_q   <= out_instr_d;
      out_err_q     <= out_err_d;
      cnt_words_q   <= cnt_words_d;
      cnt_errs_q    <= cnt_errs_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_err   = out_err_q;
  assign cnt_words = cnt_words_q;
  assign cnt_errs  = cnt_errs_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed encodings from the ISA plus a randomized
// stream with random backpressure, compared against an arithmetic encoding model.
module tb_instr_encoder;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  typedef struct {
    int          fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } word_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_fmt;
  logic [6:0]       in_opcode;
  logic [4:0]       in_rd;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic [2:0]       in_funct3;
  logic [6:0]       in_funct7;
  logic [31:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             out_err;
  logic [CNT_W-1:0] cnt_words;
  logic [CNT_W-1:0] cnt_errs;

  int          n_checks;
  int          n_fails;
  int          sent_words;
  int          sent_errs;
  logic [32:0] rx_q[$];
  logic [32:0] exp_q[$];

  instr_encoder #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .cnt_words (cnt_words),
    .cnt_errs  (cnt_errs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every output transfer; inputs only change just after a rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) rx_q.push_back({out_err, out_instr});
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Encoding model built from the field placement table with plain arithmetic.
  function automatic logic [32:0] model(input word_t w);
    longint          v;
    longint unsigned u;
    longint unsigned r;
    bit              err;
    v   = longint'($signed(w.imm));
    u   = longint'(w.imm);
    err = 1'b0;
    r   = 0;
    case (w.fmt)
      0: r = (longint'(w.f7) << 25) + (longint'(w.rs2) << 20) + (longint'(w.rs1) << 15)
           + (longint'(w.f3) << 12) + (longint'(w.rd) << 7) + longint'(w.op);
      1: begin
        err = (v < -2048) || (v > 2047);
        r = (longint'(w.rs1) << 15) + (longint'(w.f3) << 12) + (longint'(w.rd) << 7) + longint'(w.op);
        if (!err) r = r + ((u % 4096) << 20);
      end
      2, 3: begin
        if (w.fmt == 2) err = (v < -2048) || (v > 2047);
        else            err = (v < -4096) || (v > 4094) || (u % 2 == 1);
        r = (longint'(w.rs2) << 20) + (longint'(w.rs1) << 15) + (longint'(w.f3) << 12) + longint'(w.op);
        if (!err && w.fmt == 2)
          r = r + (((u / 32) % 128) << 25) + ((u % 32) << 7);
        if (!err && w.fmt == 3)
          r = r + (((u / 4096) % 2) << 31) + (((u / 32) % 64) << 25)
                + (((u / 2) % 16) << 8) + (((u / 2048) % 2) << 7);
      end
      4: begin
        err = (u % 4096) != 0;
        r = (longint'(w.rd) << 7) + longint'(w.op);
        if (!err) r = r + u;
      end
      5: begin
        err = (v < -1048576) || (v > 1048574) || (u % 2 == 1);
        r = (longint'(w.rd) << 7) + longint'(w.op);
        if (!err)
          r = r + (((u / 1048576) % 2) << 31) + (((u / 2) % 1024) << 21)
                + (((u / 2048) % 2) << 20) + (((u / 4096) % 256) << 12);
      end
      default: begin
        err = 1'b1;
        r   = 0;
      end
    endcase
    return {err, r[31:0]};
  endfunction

  function automatic word_t mk(input int fmt, input logic [6:0] op, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [31:0] imm);
    word_t w;
    w.fmt = fmt; w.op = op; w.rd = rd; w.rs1 = rs1; w.rs2 = rs2;
    w.f3 = f3; w.f7 = f7; w.imm = imm;
    return w;
  endfunction

  function automatic word_t rand_word();
    word_t w;
    int    bounds[14];
    logic [32:0] m;
    bounds = '{2047, 2048, -2048, -2049, 4094, 4096, -4096, -4098,
               1048574, 1048576, -1048576, -1048578, 4095, 3};
    w.fmt = $urandom_range(0, 7);
    w.op  = 7'($urandom);
    w.rd  = 5'($urandom);
    w.rs1 = 5'($urandom);
    w.rs2 = 5'($urandom);
    w.f3  = 3'($urandom);
    w.f7  = 7'($urandom);
    case ($urandom_range(0, 3))
      0: w.imm = $urandom;
      1: w.imm = 32'($signed($urandom_range(0, 10000)) - 5000);
      2: w.imm = 32'(bounds[$urandom_range(0, 13)]);
      default: w.imm = $urandom & 32'hFFFF_F000;
    endcase
    m = model(w);
    return w;
  endfunction

  function automatic int sat(input int n);
    return (n > CNT_MAX) ? CNT_MAX : n;
  endfunction

  task automatic set_inputs(input word_t w);
    in_fmt    = 3'(w.fmt);
    in_opcode = w.op;
    in_rd     = w.rd;
    in_rs1    = w.rs1;
    in_rs2    = w.rs2;
    in_funct3 = w.f3;
    in_funct7 = w.f7;
    in_imm    = w.imm;
  endtask

  // Offer one word starting just after a rising edge; returns just after the accepting edge.
  task automatic drive_word(input word_t w);
    bit          ok;
    logic [32:0] m;
    set_inputs(w);
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fails++;
      $display("[TB] FAIL accept_timeout: in_ready stayed 0, required 1 within 200 cycles");
    end else begin
      m = model(w);
      exp_q.push_back(m);
      sent_words++;
      if (m[32]) sent_errs++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_inputs(mk(0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_out_valid: got %b required 0", out_valid); end
    n_checks++; if (out_instr !== 32'h0) begin n_fails++; $display("[TB] FAIL reset_out_instr: got %h required 0", out_instr); end
    n_checks++; if (out_err !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_out_err: got %b required 0", out_err); end
    n_checks++; if (cnt_words !== '0 || cnt_errs !== '0) begin n_fails++; $display("[TB] FAIL reset_counters: got %0d/%0d required 0/0", cnt_words, cnt_errs); end
    n_checks++; if (in_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL reset_in_ready: got %b required 1", in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_addi();
    rx_q.delete(); exp_q.delete();
    out_ready = 1'b1;
    drive_word(mk(1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5));
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL addi_latency_early: out_valid %b required 0 one cycle after accept", out_valid); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) begin n_fails++; $display("[TB] FAIL addi_latency: out_valid %b required 1 two cycles after accept", out_valid); end
    n_checks++; if (out_instr !== 32'h0050_0093 || out_err !== 1'b0) begin n_fails++; $display("[TB] FAIL addi_word: got %h err %b required 00500093 err 0", out_instr, out_err); end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_back_to_back();
    time t0;
    logic [31:0] want[3];
    want = '{32'h0020_81B3, 32'h0020_A423, 32'h1234_52B7};
    rx_q.delete(); exp_q.delete();
    out_ready = 1'b1;
    t0 = $time;
    drive_word(mk(0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0));
    drive_word(mk(2, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8));
    drive_word(mk(4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000));
    n_checks++; if ($time - t0 != 30) begin n_fails++; $display("[TB] FAIL b2b_throughput: 3 words took %0t required 30", $time - t0); end
    drain();
    n_checks++; if (rx_q.size() != 3) begin n_fails++; $display("[TB] FAIL b2b_count: got %0d words required 3", rx_q.size()); end
    for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== {1'b0, want[i]}) begin n_fails++; $display("[TB] FAIL b2b_word%0d: got %h required %h", i, rx_q[i], {1'b0, want[i]}); end
    end
    n_checks++; if (int'(cnt_words) != sat(sent_words)) begin n_fails++; $display("[TB] FAIL b2b_cnt_words: got %0d required %0d", cnt_words, sat(sent_words)); end
  endtask

  task automatic test_branch_jump();
    int errs0;
    errs0 = sent_errs;
    rx_q.delete(); exp_q.delete();
    out_ready = 1'b1;
    drive_word(mk(3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC));
    drive_word(mk(5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8));
    drive_word(mk(3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3));
    drain();
    n_checks++; if (rx_q.size() != 3) begin n_fails++; $display("[TB] FAIL bj_count: got %0d words required 3", rx_q.size()); end
    else begin
      n_checks++; if (rx_q[0] !== {1'b0, 32'hFE00_0EE3}) begin n_fails++; $display("[TB] FAIL beq_word: got %h required 0fe000ee3", rx_q[0]); end
      n_checks++; if (rx_q[1] !== {1'b0, 32'h0080_00EF}) begin n_fails++; $display("[TB] FAIL jal_word: got %h required 0008000ef", rx_q[1]); end
      n_checks++; if (rx_q[2] !== {1'b1, 32'h0000_0063}) begin n_fails++; $display("[TB] FAIL b_odd_word: got %h required 100000063", rx_q[2]); end
    end
    n_checks++; if (int'(cnt_errs) != sat(errs0 + 1)) begin n_fails++; $display("[TB] FAIL b_odd_cnt_errs: got %0d required %0d", cnt_errs, sat(errs0 + 1)); end
  endtask

  task automatic test_range();
    rx_q.delete(); exp_q.delete();
    out_ready = 1'b1;
    drive_word(mk(1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048));
    drive_word(mk(1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800));
    drive_word(mk(7, 7'b0010011, 5'd1, 5'd3, 5'd4, 3'd5, 7'd9, 32'd0));
    drain();
    n_checks++; if (rx_q.size() != 3) begin n_fails++; $display("[TB] FAIL range_count: got %0d words required 3", rx_q.size()); end
    else begin
      n_checks++; if (rx_q[0] !== {1'b1, 32'h0000_0093}) begin n_fails++; $display("[TB] FAIL range_i_2048: got %h required 100000093", rx_q[0]); end
      n_checks++; if (rx_q[1] !== {1'b0, 32'h8000_0093}) begin n_fails++; $display("[TB] FAIL range_i_m2048: got %h required 080000093", rx_q[1]); end
      n_checks++; if (rx_q[2] !== {1'b1, 32'h0000_0000}) begin n_fails++; $display("[TB] FAIL range_fmt7: got %h required 100000000", rx_q[2]); end
    end
  endtask

  task automatic test_backpressure();
    word_t       w[4];
    logic [32:0] m0;
    for (int i = 0; i < 4; i++) w[i] = rand_word();
    rx_q.delete(); exp_q.delete();
    out_ready = 1'b0;
    drive_word(w[0]);
    drive_word(w[1]);
    m0 = model(w[0]);
    set_inputs(w[2]);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL bp_in_ready_low: got %b required 0 (cycle %0d)", in_ready, i); end
      n_checks++; if (out_valid !== 1'b1 || {out_err, out_instr} !== m0) begin n_fails++; $display("[TB] FAIL bp_hold: got v%b %h required v1 %h", out_valid, {out_err, out_instr}, m0); end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL bp_in_ready_rise: got %b required 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back(model(w[2]));
    sent_words++;
    if (model(w[2]) >> 32) sent_errs++;
    drive_word(w[3]);
    drain();
    n_checks++; if (rx_q.size() != 4) begin n_fails++; $display("[TB] FAIL bp_count: got %0d words required 4", rx_q.size()); end
    for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
      n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fails++; $display("[TB] FAIL bp_order%0d: got %h required %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    bit done;
    int nbad;
    rx_q.delete(); exp_q.delete();
    done = 1'b0;
    nbad = 0;
    fork
      begin
        for (int i = 0; i < 200; i++) drive_word(rand_word());
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
      end
    join
    drain();
    n_checks++; if (rx_q.size() != exp_q.size()) begin n_fails++; $display("[TB] FAIL rand_count: got %0d words required %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp_q[i]) begin
        n_fails++;
        $display("[TB] FAIL rand_word%0d: got %h required %h", i, rx_q[i], exp_q[i]);
      end
    end
    n_checks++; if (int'(cnt_words) != sat(sent_words)) begin n_fails++; $display("[TB] FAIL sat_cnt_words: got %0d required %0d", cnt_words, sat(sent_words)); end
    n_checks++; if (int'(cnt_errs) != sat(sent_errs)) begin n_fails++; $display("[TB] FAIL sat_cnt_errs: got %0d required %0d", cnt_errs, sat(sent_errs)); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    drive_word(rand_word());
    drive_word(rand_word());
    rx_q.delete(); exp_q.delete();
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_instr !== 32'h0) begin n_fails++; $display("[TB] FAIL mid_reset_out: got v%b %h required v0 0", out_valid, out_instr); end
    n_checks++; if (cnt_words !== '0 || cnt_errs !== '0) begin n_fails++; $display("[TB] FAIL mid_reset_counters: got %0d/%0d required 0/0", cnt_words, cnt_errs); end
    sent_words = 0;
    sent_errs  = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL mid_reset_in_ready: got %b required 1", in_ready); end
    drain();
    n_checks++; if (rx_q.size() != 0) begin n_fails++; $display("[TB] FAIL mid_reset_ghost: %0d stale words emitted, required 0", rx_q.size()); end
    drive_word(mk(1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5));
    drain();
    n_checks++; if (rx_q.size() != 1 || rx_q[0] !== {1'b0, 32'h0050_0093}) begin n_fails++; $display("[TB] FAIL post_reset_word: got %0d words first %h required 1 word 000500093", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 33'h0); end
    n_checks++; if (cnt_words !== 4'd1) begin n_fails++; $display("[TB] FAIL post_reset_cnt: got %0d required 1", cnt_words); end
  endtask

  initial begin
    n_checks = 0; n_fails = 0; sent_words = 0; sent_errs = 0;
    test_reset();
    test_addi();
    test_back_to_back();
    test_branch_jump();
    test_range();
    test_backpressure();
    test_random();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Pipelined RISC-V RV32I instruction encoder, the inverse of the immediate generator. It accepts decoded fields (format, opcode, registers, funct bits, full 32-bit immediate) and packs them into a 32-bit instruction word. The immediate is range-checked per format before packing. It sits between the test/boot sequencer and the instruction-memory writer, with valid/ready handshakes on both sides.

## Interface
- `CNT_W`, default 16: width of the accepted-word and error counters.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: input fields are valid.
- `in_ready` out 1: encoder can accept this cycle.
- `in_fmt` in 3: format code `FMT_R/I/S/B/U/J` = 0..5; values 6 and 7 are illegal.
- `in_opcode` in 7: opcode, copied verbatim to bits [6:0].
- `in_rd`, `in_rs1`, `in_rs2` in 5 each: register indices.
- `in_funct3` in 3, `in_funct7` in 7: function fields.
- `in_imm` in 32: full signed immediate value; for U-format, the final value including the low 12 bits.
- `out_valid` out 1: output word valid.
- `out_ready` in 1: downstream accepts.
- `out_instr` out 32: encoded instruction.
- `out_err` out 1: the immediate or format was illegal for this word.
- `cnt_words` out CNT_W: saturating count of words delivered.
- `cnt_errs` out CNT_W: saturating count of delivered words with `out_err` set.

## Operation
- Field placement per format; fields a format does not use are ignored:
  - R: {funct7, rs2, rs1, f3, rd, op}
  - I: {imm[11:0], rs1, f3, rd, op}
  - S: {imm[11:5], rs2, rs1, f3, imm[4:0], op}
  - B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}
  - U: {imm[31:12], rd, op}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}
- Legality checks, with `in_imm` treated as signed:
  - I/S: -2048..2047.
  - B: -4096..4094, and imm[0]=0.
  - J: -1048576..1048574, and imm[0]=0.
  - U: imm[11:0]=0.
  - R: immediate ignored, always legal.
  - Formats 6 and 7: always illegal.
- On an illegal word, `out_err`=1 and all immediate bit positions of `out_instr` are forced to 0. The other fields are packed normally. For formats 6/7, `out_instr`=32'h0000_0000.
- Pipeline: stage S1 registers the fields plus the computed error flag. Stage S2 registers the packed word.
- Handshake: a transfer occurs when valid&&ready.
  - Each stage advances when its consumer takes its data or the stage is empty.
  - `in_ready` = !s1_valid || (!s2_valid || out_ready).
  - `in_ready` must not depend combinationally on `in_valid`.
  - `out_valid` and `out_instr` hold stable while `out_valid && !out_ready`.
- Counters increment on each output transfer and saturate at all-ones. They do not wrap.
- Reset values: `out_valid`=0, `out_instr`=0, `out_err`=0, both counters 0, both stage-valid bits 0. Because the stages are empty, `in_ready` is 1 after reset.
- Reset asserted mid-operation discards all in-flight words immediately. No partial word is ever emitted.

## Timing
- Latency: 2 cycles from input transfer edge to `out_valid` high, with `out_ready` held 1.
- Throughput: 1 word/cycle with `out_ready` held 1.
- Backpressure: with `out_ready`=0, two words are absorbed (S1 and S2 full), then `in_ready` falls. `in_ready` rises in the same cycle `out_ready` returns.
- Simultaneous input and output transfer with both stages full: S2 takes S1 and S1 takes the input in the same edge. No bubble.
- Counters update on the same edge as the output transfer and are visible the following cycle.

## Structure
- Shared package `rv_isa_pkg` contains:
  - format enum `fmt_t` (R, I, S, B, U, J);
  - opcode constants `OP_R`=7'b0110011, `OP_IMM`=7'b0010011, `OP_STORE`=7'b0100011, `OP_BRANCH`=7'b1100011, `OP_LUI`=7'b0110111, `OP_JAL`=7'b1101111;
  - immediate range constants.
  The decode-side immediate generator consumes the same package.
- One combinational sub-module, `imm_pack`: inputs format and immediate, outputs the 32-bit packed immediate/field mask and the error flag. It is instantiated in S1/S2. Handshake and counters stay in the top module.

## Test plan
- addi x1,x0,5 (I, op 0010011, rd=1, rs1=0, f3=0, imm=5) -> `out_instr`=0x00500093, `out_err`=0, 2 cycles later.
- Back-to-back stream with `out_ready`=1:
  - add x3,x1,x2 (R, funct7=0) -> 0x002081B3;
  - sw x2,8(x1) -> 0x0020A423;
  - lui x5 imm=0x12345000 -> 0x123452B7;
  - one per cycle, `cnt_words`=3.
- Branch and jump:
  - beq x0,x0,imm=-4 -> 0xFE000EE3;
  - jal x1,imm=8 -> 0x008000EF;
  - B imm=3 (odd) -> `out_err`=1, immediate bits zero, `cnt_errs`+1.
- Range: I imm=2048 -> `out_err`=1; I imm=-2048 -> legal, 0x80000093 with rd=1; fmt=7 -> `out_instr`=0, `out_err`=1.
- Backpressure: hold `out_ready`=0 and offer 4 words.
  - Exactly 2 are accepted, `in_ready`=0, and the output stays stable.
  - When `out_ready` is released, all 4 are delivered in order with no loss or duplication.
- Async reset mid-stream (S1 and S2 full) -> `out_valid`=0 immediately, counters 0, `in_ready`=1 after release, and the old words are never emitted.
